// File: rtl/sar_conv_scheduler.sv
`timescale 1ns/1ps
// Round-robin / single-sweep channel sequencer driving a SAR ADC and emitting tagged results.
// Latency: PICK to res_valid = 1 + SETTLE + (cycles to eoc) + 1 clk.
// Backpressure: res_data/res_ch held while res_valid & !res_ready; no new conversion starts until accepted.
module sar_conv_scheduler #(
    parameter int N_CH    = 4,
    parameter int N_BITS  = 10,
    parameter int SETTLE  = 3,
    parameter int TIMEOUT = 255,
    parameter int CH_W    = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sweep_req,
    input  logic [N_CH-1:0]   ch_mask,
    output logic [CH_W-1:0]   adc_sel,
    output logic              adc_hold,
    input  logic              adc_eoc,
    input  logic [N_BITS-1:0] adc_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N_BITS-1:0] res_data,
    output logic [CH_W-1:0]   res_ch,
    output logic              sweep_done,
    output logic              busy,
    output logic              timeout_err,
    output logic [CH_W-1:0]   err_ch,
    input  logic              err_clr
);

    localparam int CNT_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        SETTLE_ST,
        HOLD,
        CAPTURE,
        OUTPUT,
        RECOVER
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   sel_q, sel_d;
    logic [CH_W-1:0]   last_ch_q, last_ch_d;
    logic              hold_q, hold_d;
    logic              eoc_q;
    logic [N_BITS-1:0] res_data_q, res_data_d;
    logic [CH_W-1:0]   res_ch_q, res_ch_d;
    logic              valid_q, valid_d;
    logic              sweep_active_q, sweep_active_d;
    logic [CH_W-1:0]   sweep_start_q, sweep_start_d;
    logic              sweep_pend_q, sweep_pend_d;
    logic              done_q, done_d;
    logic              terr_q, terr_d;
    logic [CH_W-1:0]   err_ch_q, err_ch_d;

    logic              nxt_found;
    logic [CH_W-1:0]   nxt_ch;
    logic              eoc_edge;
    logic              start_now;

    // First set mask bit strictly after 'last', wrapping; offset N_CH re-picks 'last' itself.
    function automatic logic [CH_W:0] next_ch(input logic [CH_W-1:0] last,
                                              input logic [N_CH-1:0] mask);
        logic [CH_W:0] r;
        int            idx;
        r = '0;
        for (int k = N_CH; k >= 1; k--) begin
            idx = (int'(last) + k) % N_CH;
            if (mask[idx]) begin
                r = {1'b1, CH_W'(idx)};
            end
        end
        return r;
    endfunction

    always_comb begin
        {nxt_found, nxt_ch} = next_ch(last_ch_q, ch_mask);
    end

    assign eoc_edge = adc_eoc & ~eoc_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        sel_d          = sel_q;
        last_ch_d      = last_ch_q;
        res_data_d     = res_data_q;
        res_ch_d       = res_ch_q;
        sweep_active_d = sweep_active_q;
        sweep_start_d  = sweep_start_q;
        sweep_pend_d   = sweep_pend_q;
        done_d         = 1'b0;
        terr_d         = terr_q;
        err_ch_d       = err_ch_q;
        start_now      = 1'b0;

        if (err_clr) begin
            terr_d = 1'b0;
        end
        if (state_q != IDLE && sweep_req) begin
            sweep_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                start_now = sweep_req | sweep_pend_q;
                sweep_pend_d = 1'b0;
                if (ch_mask == '0) begin
                    if (sweep_active_q | start_now) begin
                        done_d = 1'b1;
                    end
                    sweep_active_d = 1'b0;
                end else begin
                    if (start_now && !sweep_active_q) begin
                        sweep_active_d = 1'b1;
                        sweep_start_d  = nxt_ch;
                    end
                    if (enable | sweep_active_d) begin
                        state_d = PICK;
                    end
                end
            end
            PICK: begin
                if (nxt_found) begin
                    sel_d     = nxt_ch;
                    last_ch_d = nxt_ch;
                    cnt_d     = CNT_W'(1);
                    state_d   = SETTLE_ST;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE_ST: begin
                if (cnt_q >= CNT_W'(SETTLE)) begin
                    cnt_d   = CNT_W'(1);
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                // An eoc edge in the timeout cycle still counts as a valid conversion.
                if (eoc_edge) begin
                    state_d = CAPTURE;
                end else if (cnt_q >= CNT_W'(TIMEOUT)) begin
                    terr_d   = 1'b1;
                    err_ch_d = sel_q;
                    cnt_d    = CNT_W'(1);
                    state_d  = RECOVER;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAPTURE: begin
                res_data_d = adc_result;
                res_ch_d   = sel_q;
                last_ch_d  = sel_q;
                state_d    = OUTPUT;
            end
            OUTPUT: begin
                if (res_ready) begin
                    cnt_d   = CNT_W'(1);
                    state_d = RECOVER;
                end
            end
            RECOVER: begin
                if (cnt_q < CNT_W'(2)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (!adc_eoc) begin
                    if (sweep_active_q && (!nxt_found || nxt_ch == sweep_start_q)) begin
                        done_d         = 1'b1;
                        sweep_active_d = 1'b0;
                        state_d        = IDLE;
                    end else if (sweep_pend_q && !sweep_active_q) begin
                        sweep_active_d = 1'b1;
                        sweep_start_d  = nxt_ch;
                        sweep_pend_d   = 1'b0;
                        state_d        = PICK;
                    end else if (enable | sweep_active_q) begin
                        state_d = PICK;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        hold_d  = (state_d == HOLD);
        valid_d = (state_d == OUTPUT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            sel_q          <= '0;
            last_ch_q      <= CH_W'(N_CH - 1);
            hold_q         <= 1'b0;
            eoc_q          <= 1'b0;
            res_data_q     <= '0;
            res_ch_q       <= '0;
            valid_q        <= 1'b0;
            sweep_active_q <= 1'b0;
            sweep_start_q  <= '0;
            sweep_pend_q   <= 1'b0;
            done_q         <= 1'b0;
            terr_q         <= 1'b0;
            err_ch_q       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sel_q          <= sel_d;
            last_ch_q      <= last_ch_d;
            hold_q         <= hold_d;
            eoc_q          <= adc_eoc;
            res_data_q     <= res_data_d;
            res_ch_q       <= res_ch_d;
            valid_q        <= valid_d;
            sweep_active_q <= sweep_active_d;
            sweep_start_q  <= sweep_start_d;
            sweep_pend_q   <= sweep_pend_d;
            done_q         <= done_d;
            terr_q         <= terr_d;
            err_ch_q       <= err_ch_d;
        end
    end

    assign adc_sel     = sel_q;
    assign adc_hold    = hold_q;
    assign res_valid   = valid_q;
    assign res_data    = res_data_q;
    assign res_ch      = res_ch_q;
    assign sweep_done  = done_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = terr_q;
    assign err_ch      = err_ch_q;

endmodule

// File: doc/sar_conv_scheduler.md
Name: sar_conv_scheduler

Overview:
- Multi-channel conversion sequencer for the sar_adc__N_BITS_10 datapath.
- Selects one analog channel through an external mux and drives input_hold_digital to the ADC.
- Waits for eoc, captures output_result_digital, and presents a tagged result on a valid/ready stream.
- Sits between the ADC instance and the system result consumer; supports round-robin continuous scanning and single-sweep mode.

Parameters:
- N_CH, 4, number of analog channels (2..16).
- N_BITS, 10, ADC result width.
- SETTLE, 3, clk cycles of mux settling before hold is asserted (>=1).
- TIMEOUT, 255, max clk cycles in HOLD waiting for eoc before abort (>=4).
- CH_W, $clog2(N_CH), channel index width (derived).

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-low reset.
- enable, in, 1, continuous-scan enable.
- sweep_req, in, 1, single-pulse request for one pass over ch_mask.
- ch_mask, in, N_CH, channels included in the scan; sampled at each channel pick.
- adc_sel, out, CH_W, analog mux select.
- adc_hold, out, 1, drives ADC input_hold_digital.
- adc_eoc, in, 1, ADC eoc, already synchronous to clk.
- adc_result, in, N_BITS, ADC output_result_digital.
- res_valid, out, 1, result available.
- res_ready, in, 1, consumer accepts result.
- res_data, out, N_BITS, captured conversion.
- res_ch, out, CH_W, channel of res_data.
- sweep_done, out, 1, one-cycle pulse when a single sweep finishes.
- busy, out, 1, high in any state other than IDLE.
- timeout_err, out, 1, sticky abort flag.
- err_ch, out, CH_W, channel of the most recent timeout.
- err_clr, in, 1, clears timeout_err.

Behaviour:
- Reset (reset=0, async): all outputs 0; state IDLE; last_ch = N_CH-1, so the first pick is channel 0 when mask bit 0 is set; sweep_active=0. Reset mid-conversion drops adc_hold immediately.
- States: IDLE, PICK, SETTLE, HOLD, CAPTURE, OUTPUT, RECOVER.
- IDLE:
  - sweep_req=1 sets sweep_active and sweep_start = next enabled channel after last_ch.
  - IDLE -> PICK when (enable | sweep_active) and ch_mask != 0.
  - With ch_mask == 0: stay in IDLE; a pending sweep_active is cleared and sweep_done pulses.
- PICK (1 cycle):
  - Next channel = first set bit of ch_mask strictly after last_ch, wrapping modulo N_CH. If only last_ch is set, it is re-picked.
  - adc_sel is registered here and held stable until the next PICK.
  - -> SETTLE.
- SETTLE: count SETTLE cycles, then -> HOLD.
- HOLD:
  - adc_hold=1.
  - A rising edge on adc_eoc (eoc_q=0, adc_eoc=1) -> CAPTURE.
  - A clk cycle counter runs; at count == TIMEOUT with no edge: adc_hold=0, timeout_err=1, err_ch=adc_sel, -> RECOVER with no result produced.
  - An eoc edge and the timeout in the same cycle: the edge wins.
- CAPTURE (1 cycle): res_data <= adc_result, res_ch <= adc_sel, adc_hold <= 0, last_ch <= adc_sel, -> OUTPUT.
- OUTPUT:
  - res_valid=1; res_data and res_ch stable while valid & !ready.
  - On ready: res_valid=0 in the next cycle, -> RECOVER.
- RECOVER:
  - adc_hold stays 0 for at least 2 cycles and until adc_eoc=0.
  - Then, if sweep_active and the next pick would return to sweep_start: pulse sweep_done, clear sweep_active, -> IDLE.
  - Else if enable | sweep_active: -> PICK. Otherwise -> IDLE.
- Deasserting enable mid-conversion does not abort; the current channel completes through OUTPUT.
- A sweep_req received while busy is latched and serviced after the current conversion.
- err_clr clears timeout_err; a new timeout in the same cycle wins (flag stays 1).
- Latency from PICK to res_valid = 1 + SETTLE + (cycles to eoc) + 1.

Test Plan:
- ch_mask=4'b1011, enable=1, ADC model returns 10*ch+5 with eoc 20 cycles after hold -> results ch0=5, ch1=15, ch3=35, ch0=5 in order; ch2 never selected; adc_sel stable during each HOLD.
- sweep_req pulse, ch_mask=4'b0110, enable=0 -> exactly two results (ch1=15, ch2=25), then sweep_done pulses once and busy=0.
- res_ready held 0 for 50 cycles while in OUTPUT -> res_valid stays 1, res_data and res_ch unchanged, adc_hold=0, no new PICK.
- ADC model never raises eoc on ch2, TIMEOUT=255 -> adc_hold drops at cycle 255 of HOLD, timeout_err=1, err_ch=2, scan continues with ch3. err_clr=1 -> timeout_err=0.
- reset asserted while in HOLD -> adc_hold=0 and res_valid=0 asynchronously. After release, the first conversion is ch0.
- ch_mask=0 with enable=1 -> busy stays 0 and adc_hold never rises. Changing the mask to 4'b1000 starts scanning ch3 repeatedly.
